// File: rtl/spi_link_pkg.sv
// Shared definitions for the 4-lane camera SPI link (receiver and sender).
package spi_link_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int LINES      = 4;

    typedef logic [DATA_WIDTH-1:0] pixel_t;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/spi_rx_sync.sv
// N-bit, STAGES-deep flip-flop synchronizer with asynchronous reset to 0.
module spi_rx_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // Shift the asynchronous inputs through the synchronizer chain.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
        end else begin
            r_stage[0] <= d_in;
            for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
        end
    end

    assign q_out = r_stage[STAGES-1];

endmodule

// File: rtl/spi_pixel_receiver.sv
// Main-board receiver for the 4-lane camera SPI link: synchronizes the link,
// deserializes each chip-select burst into LINES pixels and streams them out.
// Optional feature macro: SPI_RX_FRAME_CHECK_EN (short-burst flag, burst counter).
//
// state    | meaning
// RX_IDLE  | waiting for cs falling edge
// RX_SHIFT | shifting lanes on dclk rising edges until cs rises
module spi_pixel_receiver
    import spi_link_pkg::*;
#(
    parameter int DATA_WIDTH  = spi_link_pkg::DATA_WIDTH,
    parameter int LINES       = spi_link_pkg::LINES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  dclk,
    input  logic [LINES-1:0]      cipo,
    input  logic                  cs,
    input  logic                  spi_hsync,
    input  logic                  spi_vsync,
    output logic [DATA_WIDTH-1:0] pixel_data_out,
    output logic                  pixel_valid_out,
    input  logic                  pixel_ready_in,
    output logic                  pixel_last_out,
    output logic                  pixel_first_out,
`ifdef SPI_RX_FRAME_CHECK_EN
    output logic                  short_burst_out,
    output logic [15:0]           burst_count_out,
`endif
    output logic                  overflow_out
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;

    logic [LINES+3:0]      w_sync;
    logic [LINES-1:0]      w_cipo;
    logic                  w_dclk, w_cs, w_hsync, w_vsync;
    logic                  w_dclk_rise, w_cs_fall, w_cs_rise, w_vsync_rise;
    logic                  w_fire, w_empty_now, w_accept;

    rx_state_t             r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shift [LINES];
    logic                  r_done, r_done_last;
    logic                  r_dclk_d, r_cs_d, r_vsync_d;
    logic [DATA_WIDTH-1:0] r_pix [LINES];
    logic [IW-1:0]         r_idx;
    logic                  r_full, r_buf_last, r_buf_first;
    logic                  r_first_pending, r_overflow;
`ifdef SPI_RX_FRAME_CHECK_EN
    logic                  r_short_burst;
    logic [15:0]           r_burst_count;
`endif

    spi_rx_sync #(.WIDTH(LINES + 4), .STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   ({spi_vsync, spi_hsync, cs, dclk, cipo}),
        .q_out  (w_sync)
    );

    assign w_cipo  = w_sync[LINES-1:0];
    assign w_dclk  = w_sync[LINES];
    assign w_cs    = w_sync[LINES+1];
    assign w_hsync = w_sync[LINES+2];
    assign w_vsync = w_sync[LINES+3];

    assign w_dclk_rise  = w_dclk & ~r_dclk_d;
    assign w_cs_fall    = ~w_cs & r_cs_d;
    assign w_cs_rise    = w_cs & ~r_cs_d;
    assign w_vsync_rise = w_vsync & ~r_vsync_d;

    // Delayed copies of the synchronized strobes for edge detection.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_dclk_d  <= 1'b0;
            r_cs_d    <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_dclk_d  <= w_dclk;
            r_cs_d    <= w_cs;
            r_vsync_d <= w_vsync;
        end
    end

    // RX state machine: deserialize lanes; flag a complete burst for one cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_done_last <= 1'b0;
            for (int i = 0; i < LINES; i++) r_shift[i] <= '0;
`ifdef SPI_RX_FRAME_CHECK_EN
            r_short_burst <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_cs_fall) begin
                        r_cnt   <= '0;
                        for (int i = 0; i < LINES; i++) r_shift[i] <= '0;
                        r_state <= RX_SHIFT;
                    end
                end
                RX_SHIFT: begin
                    if (w_cs_rise) begin
                        r_state <= RX_IDLE;
                        if (r_cnt == CW'(DATA_WIDTH)) begin
                            r_done      <= 1'b1;
                            r_done_last <= w_hsync;
                        end
`ifdef SPI_RX_FRAME_CHECK_EN
                        else r_short_burst <= 1'b1;
`endif
                    end else if (w_dclk_rise && (r_cnt != CW'(DATA_WIDTH))) begin
                        // Counter saturates at DATA_WIDTH; extra edges shift nothing.
                        for (int i = 0; i < LINES; i++)
                            r_shift[i] <= {r_shift[i][DATA_WIDTH-2:0], w_cipo[i]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign w_fire      = r_full & pixel_ready_in;
    assign w_empty_now = w_fire & (r_idx == IW'(LINES - 1));
    assign w_accept    = r_done & (~r_full | w_empty_now);

    // Output buffer: load a complete burst when free (or freeing this cycle).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < LINES; i++) r_pix[i] <= '0;
            r_idx       <= '0;
            r_full      <= 1'b0;
            r_buf_last  <= 1'b0;
            r_buf_first <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < LINES; i++) r_pix[i] <= r_shift[i];
                r_idx       <= '0;
                r_full      <= 1'b1;
                r_buf_last  <= r_done_last;
                r_buf_first <= r_first_pending;
            end else if (w_fire) begin
                if (r_idx == IW'(LINES - 1)) begin
                    r_full <= 1'b0;
                    r_idx  <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (r_done && !w_accept) r_overflow <= 1'b1;
        end
    end

    // Start-of-frame pending flag, consumed by the next accepted burst.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)            r_first_pending <= 1'b0;
        else if (w_vsync_rise) r_first_pending <= 1'b1;
        else if (w_accept)     r_first_pending <= 1'b0;
    end

`ifdef SPI_RX_FRAME_CHECK_EN
    // Complete bursts since the last vsync rising edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)            r_burst_count <= '0;
        else if (w_vsync_rise) r_burst_count <= {15'd0, r_done};
        else if (r_done)       r_burst_count <= r_burst_count + 16'd1;
    end

    assign short_burst_out = r_short_burst;
    assign burst_count_out = r_burst_count;
`endif

    assign pixel_valid_out = r_full;
    assign pixel_data_out  = r_full ? r_pix[r_idx] : '0;
    assign pixel_last_out  = r_full & r_buf_last & (r_idx == IW'(LINES - 1));
    assign pixel_first_out = r_full & r_buf_first & (r_idx == '0);
    assign overflow_out    = r_overflow;

endmodule

// File: doc/spi_pixel_receiver.md
# spi_pixel_receiver

Main-board end of the 4-lane camera SPI link. Samples `dclk`, `cipo[3:0]`, `cs`, `spi_hsync` and `spi_vsync` from the peripheral board, deserializes each chip-select burst into `LINES` pixels, and emits them one pixel per cycle as a valid/ready stream. The stream carries end-of-frame and start-of-frame flags and feeds the downstream frame buffer and depth pipeline.

## Interface
- `DATA_WIDTH`, 8: bits per pixel, and dclk edges per burst.
- `LINES`, 4: parallel data lanes. Lane i carries pixel i of the burst.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on every link input.
- `clk_in` input 1: system clock, 200 MHz.
- `rst_in` input 1: reset, asynchronous, active-high.
- `dclk` input 1: SPI data clock from the peripheral.
- `cipo` input LINES: serial data lanes, MSB first.
- `cs` input 1: chip select, active-low, one burst per assertion.
- `spi_hsync` input 1: end-of-frame marker (tlast).
- `spi_vsync` input 1: camera vsync, passed through the link.
- `pixel_data_out` output DATA_WIDTH: pixel value.
- `pixel_valid_out` output 1: `pixel_data_out` is valid.
- `pixel_ready_in` input 1: downstream accepts the pixel.
- `pixel_last_out` output 1: last pixel of the frame.
- `pixel_first_out` output 1: first pixel after a vsync rising edge.
- `overflow_out` output 1: sticky; a burst was dropped.

## Operation
- All five link inputs pass through `SYNC_STAGES` flops. Edge detectors act on the synchronized copies only.
- RX states:
  - IDLE: waits for `cs` falling edge; clears the bit counter and all lane shift registers, then goes to SHIFT.
  - SHIFT: on each synchronized `dclk` rising edge, shifts each lane's `cipo[i]` into shift register i at the LSB and increments the bit counter.
  - `cs` rising edge in SHIFT goes to IDLE. If the counter equals `DATA_WIDTH` at that edge, the burst is complete; otherwise it is discarded.
  - Further `dclk` edges beyond `DATA_WIDTH` are ignored; the counter saturates. A saturated counter is still a complete burst.
- Complete burst: latches the LINES pixels into the output buffer, plus a last tag equal to synchronized `spi_hsync` sampled at the `cs` rising edge.
- Output buffer: emits pixel 0 first, through pixel LINES-1. The index advances on each `valid && ready`.
  - `pixel_last_out` is high only with pixel LINES-1 of a tagged burst.
  - `pixel_first_out` is high with pixel 0 of the first complete burst after a synchronized `spi_vsync` rising edge; the pending flag then clears.
- Overflow: a burst completes while the buffer still holds unsent pixels. The new burst is dropped, the buffer is untouched, and `overflow_out` sets and stays high until reset.
- Simultaneous events: the buffer empties in the same cycle a burst completes. The new burst is accepted and there is no overflow.
- Reset, asynchronous at any point: state IDLE, counter 0, buffer empty, first-pending flag clear. A burst in flight is lost; RX resyncs on the next `cs` falling edge.

## Timing
- Output reset values: `pixel_data_out`=0, `pixel_valid_out`=0, `pixel_last_out`=0, `pixel_first_out`=0, `overflow_out`=0.
- Link requirement: `dclk` high and low phases each ≥ `SYNC_STAGES`+1 `clk_in` cycles. The peripheral's period of 12 `clk_in` cycles meets this.
- Latency: from `cs` rising at the pins to `pixel_valid_out` high is `SYNC_STAGES`+2 cycles.
- Throughput: with `pixel_ready_in` held high, LINES consecutive valid cycles per burst.
- Stream rule: data, last and first are stable while valid is high and ready is low.

## Configuration
- `SPI_RX_FRAME_CHECK_EN` defined:
  - Adds output `short_burst_out` (sticky): `cs` rose with counter < `DATA_WIDTH`.
  - Adds output `burst_count_out` [15:0]: complete bursts since the last vsync rising edge, wrapping at 65535.
- Not defined: neither port exists, and short bursts are dropped silently.

## Structure
- Package `spi_link_pkg`:
  - Holds `DATA_WIDTH` and `LINES` defaults, shared with the peripheral sender.
  - Holds typedef `pixel_t` (logic [DATA_WIDTH-1:0]) and the RX state enum (IDLE, SHIFT).
- One sub-module: `spi_rx_sync`, a parameterized N-bit, `SYNC_STAGES`-deep synchronizer with asynchronous reset to 0. It is instantiated once over the 8 link bits.

## Test plan
- Lane mapping and order: burst with lanes = 0xA5, 0x3C, 0xFF, 0x00, ready high. Expect 4 consecutive valid cycles with A5, 3C, FF, 00; last=0; overflow=0.
- Frame flags:
  - vsync pulse, then burst 0x01/02/03/04: expect first=1 on 0x01 only.
  - Burst with `spi_hsync`=1 at `cs` rise: expect last=1 on pixel 3 only.
- Backpressure: ready low for 20 cycles. Expect pixel 0 held stable, then 4 pixels in order after ready rises.
- Overflow: ready low while two complete bursts arrive. Expect the first burst retained, `overflow_out`=1 and sticky, and the second burst never emitted.
- Short burst and reset:
  - 5 dclk edges then `cs` rise: no output; `short_burst_out`=1 when the macro is enabled.
  - `rst_in` asserted mid-burst: all outputs 0 immediately; the next full burst is received correctly.
